// File: rtl/uart_cmd_ctrl.sv
// UART command front-end: strobed command decode, nibble byte assembly, prescaler/config registers,
// baud tick generation and TX handoff. Define UART_CMD_FIFO_EN for a 4-entry TX FIFO instead of 1 entry.
`timescale 1ns/1ps
module uart_cmd_ctrl #(
  parameter int                  PREDIV_W    = 10,
  parameter logic [PREDIV_W-1:0] PREDIV_RST  = 10'd103,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [6:0]          i_in7,
  input  logic                i_cmd_stb,
  input  logic                i_tx_ready,
  output logic                o_tx_valid,
  output logic [7:0]          o_tx_data,
  output logic                o_baud_tick,
  output logic [PREDIV_W-1:0] o_prediv,
  output logic [3:0]          o_cfg,
  output logic                o_resetCommandStrobe,
  output logic                o_err_overrun,
  output logic                o_err_seq
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_syncPrev;
  logic [3:0]             r_loNib;
  logic                   r_loValid;
  logic [3:0]             r_cfg;
  logic                   r_errSeq;
  logic                   r_pdPtr;
  logic [4:0]             r_shadowLo;
  logic [PREDIV_W-1:0]    r_prediv;
  logic                   r_rcs;
  logic [PREDIV_W-1:0]    r_baudCnt;
  logic                   r_tick;
  logic                   r_errOvr;

  logic       w_accept;
  logic [1:0] w_op;
  logic [4:0] w_pay;
  logic       w_isData;
  logic       w_soft;
  logic       w_cfgWr;
  logic       w_pdWr;
  logic       w_commit;
  logic       w_push;
  logic       w_pop;
  logic [7:0] w_newByte;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync     <= '0;
      r_syncPrev <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], i_cmd_stb};
      r_syncPrev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_accept  = r_sync[SYNC_STAGES-1] & ~r_syncPrev;
  assign w_op      = i_in7[1:0];
  assign w_pay     = i_in7[6:2];
  assign w_isData  = w_accept & (w_op == 2'b00);
  assign w_soft    = w_accept & (w_op == 2'b01) & (w_pay == 5'b11000);
  assign w_cfgWr   = w_accept & (w_op == 2'b01) & ~w_pay[4];
  assign w_pdWr    = w_accept & (w_op == 2'b10);
  assign w_commit  = w_pdWr & r_pdPtr;
  assign w_push    = w_isData & w_pay[4] & r_loValid;
  assign w_newByte = {w_pay[3:0], r_loNib};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_loNib    <= '0;
      r_loValid  <= 1'b0;
      r_cfg      <= '0;
      r_errSeq   <= 1'b0;
      r_pdPtr    <= 1'b0;
      r_shadowLo <= '0;
      r_prediv   <= PREDIV_RST;
      r_rcs      <= 1'b0;
    end else begin
      r_rcs <= w_soft;
      if (w_soft) begin
        r_loValid <= 1'b0;
        r_pdPtr   <= 1'b0;
        r_cfg     <= '0;
        r_errSeq  <= 1'b0;
      end else begin
        if (w_isData && !w_pay[4]) begin
          r_loNib   <= w_pay[3:0];
          r_loValid <= 1'b1;
        end else if (w_isData) begin
          if (r_loValid) r_loValid <= 1'b0;
          else           r_errSeq  <= 1'b1;
        end
        if (w_cfgWr) r_cfg <= w_pay[3:0];
        if (w_pdWr) begin
          if (!r_pdPtr) begin
            r_shadowLo <= w_pay;
            r_pdPtr    <= 1'b1;
          end else begin
            r_prediv <= {w_pay, r_shadowLo};
            r_pdPtr  <= 1'b0;
          end
        end
      end
    end
  end

  // Free-running down-counter; a prediv commit reloads it so the new rate starts immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_baudCnt <= PREDIV_RST;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= (r_baudCnt == '0);
      if (w_commit)               r_baudCnt <= {w_pay, r_shadowLo};
      else if (r_baudCnt == '0)   r_baudCnt <= r_prediv;
      else                        r_baudCnt <= r_baudCnt - 1'b1;
    end
  end

`ifdef UART_CMD_FIFO_EN
  logic [7:0] r_mem [4];
  logic [1:0] r_wrPtr;
  logic [1:0] r_rdPtr;
  logic [2:0] r_count;
  logic       w_full;
  logic       w_wr;

  assign w_pop  = (r_count != 3'd0) & i_tx_ready;
  assign w_full = (r_count == 3'd4);
  assign w_wr   = w_push & (~w_full | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_count  <= '0;
      r_errOvr <= 1'b0;
    end else if (w_soft) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_count  <= '0;
      r_errOvr <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wrPtr] <= w_newByte;
        r_wrPtr        <= r_wrPtr + 2'd1;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + 2'd1;
      r_count <= r_count + {2'b00, w_wr} - {2'b00, w_pop};
      if (w_push && w_full && !w_pop) r_errOvr <= 1'b1;
    end
  end

  assign o_tx_valid = (r_count != 3'd0);
  assign o_tx_data  = r_mem[r_rdPtr];
`else
  typedef enum logic {EMPTY, FULL} bufState_t;
  bufState_t  r_state, w_nextState;
  logic [7:0] r_txData, w_nextData;
  logic       w_nextOvr;

  assign w_pop = (r_state == FULL) & i_tx_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= EMPTY;
      r_txData <= '0;
      r_errOvr <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_txData <= w_nextData;
      r_errOvr <= w_nextOvr;
    end
  end

  // A push coinciding with a transfer refills the slot, so the buffer stays FULL.
  always_comb begin
    w_nextState = r_state;
    w_nextData  = r_txData;
    w_nextOvr   = r_errOvr;
    if (w_soft) begin
      w_nextState = EMPTY;
      w_nextOvr   = 1'b0;
    end else begin
      case (r_state)
        EMPTY: if (w_push) begin
          w_nextState = FULL;
          w_nextData  = w_newByte;
        end
        FULL: begin
          if (w_push && w_pop) w_nextData  = w_newByte;
          else if (w_push)     w_nextOvr   = 1'b1;
          else if (w_pop)      w_nextState = EMPTY;
        end
        default: w_nextState = EMPTY;
      endcase
    end
  end

  assign o_tx_valid = (r_state == FULL);
  assign o_tx_data  = r_txData;
`endif

  assign o_baud_tick          = r_tick;
  assign o_prediv             = r_prediv;
  assign o_cfg                = r_cfg;
  assign o_resetCommandStrobe = r_rcs;
  assign o_err_overrun        = r_errOvr;
  assign o_err_seq            = r_errSeq;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: vector table, directed corner sequences and a
// randomized command stream checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;

`ifdef UART_CMD_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic [6:0] in7 = '0;
  logic       cmdStb = 1'b0;
  logic       txReady = 1'b0;
  logic       txValid;
  logic [7:0] txData;
  logic       baudTick;
  logic [9:0] prediv;
  logic [3:0] cfg;
  logic       rcs;
  logic       errOvr;
  logic       errSeq;

  uart_cmd_ctrl dut (
    .i_clk(clk), .i_rst_n(rstN), .i_in7(in7), .i_cmd_stb(cmdStb), .i_tx_ready(txReady),
    .o_tx_valid(txValid), .o_tx_data(txData), .o_baud_tick(baudTick), .o_prediv(prediv),
    .o_cfg(cfg), .o_resetCommandStrobe(rcs), .o_err_overrun(errOvr), .o_err_seq(errSeq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycleCount = 0;
  int validTotal = 0;
  int rcsTotal = 0;
  logic [7:0] lastValidData = '0;
  int tickQ[$];

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Event monitor: counts valid cycles and soft-reset pulses, logs baud tick times.
  always @(negedge clk) begin
    if (txValid) begin
      validTotal++;
      lastValidData = txData;
    end
    if (rcs) rcsTotal++;
    if (baudTick) tickQ.push_back(cycleCount);
  end

  // Reference model: the TX buffer is just a bounded queue of bytes.
  logic [7:0] mq[$];
  logic       mLoValid;
  logic [3:0] mLoNib;
  logic [3:0] mCfg;
  logic [9:0] mPrediv;
  logic       mPtr;
  logic [4:0] mShadow;
  logic       mErrSeq;
  logic       mErrOvr;
  int         mExpRcs;

  typedef struct {
    logic [1:0] op;
    logic [4:0] pay;
    logic       expValid;
    logic [7:0] expData;
    logic [3:0] expCfg;
    logic [9:0] expPrediv;
    logic       expSeq;
    logic       expOvr;
    int         expRcs;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] pay, input int holdCycles);
    @(negedge clk);
    in7    = {pay, op};
    cmdStb = 1'b1;
    repeat (holdCycles) @(negedge clk);
    cmdStb = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pushByte(input logic [7:0] b);
    applyStimulus(2'b00, {1'b0, b[3:0]}, 4);
    applyStimulus(2'b00, {1'b1, b[7:4]}, 4);
  endtask

  task automatic resetModel();
    mq.delete();
    mLoValid = 1'b0; mLoNib = '0; mCfg = '0; mPrediv = 10'd103;
    mPtr = 1'b0; mShadow = '0; mErrSeq = 1'b0; mErrOvr = 1'b0; mExpRcs = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0; cmdStb = 1'b0; txReady = 1'b0; in7 = '0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    resetModel();
  endtask

  task automatic modelCmd(input logic [1:0] op, input logic [4:0] p);
    mExpRcs = 0;
    case (op)
      2'b00: begin
        if (!p[4]) begin
          mLoNib = p[3:0]; mLoValid = 1'b1;
        end else if (mLoValid) begin
          if (mq.size() < DEPTH) mq.push_back({p[3:0], mLoNib});
          else mErrOvr = 1'b1;
          mLoValid = 1'b0;
        end else mErrSeq = 1'b1;
      end
      2'b01: begin
        if (p == 5'b11000) begin
          mq.delete(); mLoValid = 1'b0; mPtr = 1'b0; mCfg = '0;
          mErrSeq = 1'b0; mErrOvr = 1'b0; mExpRcs = 1;
        end else if (!p[4]) mCfg = p[3:0];
      end
      2'b10: begin
        if (!mPtr) begin
          mShadow = p; mPtr = 1'b1;
        end else begin
          mPrediv = {p, mShadow}; mPtr = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".cfg"}, 32'(cfg), 32'(mCfg));
    checkOutput({tag, ".prediv"}, 32'(prediv), 32'(mPrediv));
    checkOutput({tag, ".errSeq"}, 32'(errSeq), 32'(mErrSeq));
    checkOutput({tag, ".errOvr"}, 32'(errOvr), 32'(mErrOvr));
    checkOutput({tag, ".valid"}, 32'(txValid), 32'(mq.size() != 0));
    if (mq.size() != 0) checkOutput({tag, ".data"}, 32'(txData), 32'(mq[0]));
  endtask

  task automatic drainAndCheck(input string tag);
    txReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (txValid) begin
        if (mq.size() == 0) checkOutput({tag, ".unexpectedByte"}, 32'(txData), 32'hFFFF_FFFF);
        else checkOutput({tag, ".drainData"}, 32'(txData), 32'(mq.pop_front()));
      end
      @(negedge clk);
    end
    txReady = 1'b0;
    checkOutput({tag, ".drainEmptyModel"}, 32'(mq.size()), 32'd0);
    checkOutput({tag, ".drainValid"}, 32'(txValid), 32'd0);
  endtask

  initial begin
    int c0, t0, v0, r0, n;
    logic [7:0] got[$];
    logic [1:0] op;
    logic [4:0] pay;

    #1 rstN = 1'b0;
    #1 rstN = 1'b1;
    doReset();

    // Reset state and idle baud behaviour
    c0 = cycleCount; t0 = tickQ.size(); v0 = validTotal;
    checkOutput("rst.valid", 32'(txValid), 0);
    checkOutput("rst.data", 32'(txData), 0);
    checkOutput("rst.tick", 32'(baudTick), 0);
    checkOutput("rst.prediv", 32'(prediv), 103);
    checkOutput("rst.cfg", 32'(cfg), 0);
    checkOutput("rst.rcs", 32'(rcs), 0);
    checkOutput("rst.errs", 32'({errOvr, errSeq}), 0);
    repeat (300) @(negedge clk);
    n = tickQ.size() - t0;
    checkOutput("idle.tickCount", 32'(n), 2);
    if (n >= 2) begin
      checkOutput("idle.firstTick", 32'(tickQ[t0] - c0), 104);
      checkOutput("idle.tickPeriod", 32'(tickQ[t0+1] - tickQ[t0]), 104);
    end
    checkOutput("idle.validCycles", 32'(validTotal - v0), 0);
    checkOutput("idle.errs", 32'({errOvr, errSeq}), 0);

    // Vector table, applied from reset state with txReady low
    vecs[0]  = '{2'b01, 5'b00101, 1'b0, 8'h00, 4'h5, 10'd103, 1'b0, 1'b0, 0};
    vecs[1]  = '{2'b01, 5'b11010, 1'b0, 8'h00, 4'h5, 10'd103, 1'b0, 1'b0, 0};
    vecs[2]  = '{2'b11, 5'b11111, 1'b0, 8'h00, 4'h5, 10'd103, 1'b0, 1'b0, 0};
    vecs[3]  = '{2'b00, 5'b10011, 1'b0, 8'h00, 4'h5, 10'd103, 1'b1, 1'b0, 0};
    vecs[4]  = '{2'b00, 5'b00101, 1'b0, 8'h00, 4'h5, 10'd103, 1'b1, 1'b0, 0};
    vecs[5]  = '{2'b00, 5'b11010, 1'b1, 8'hA5, 4'h5, 10'd103, 1'b1, 1'b0, 0};
    vecs[6]  = '{2'b10, 5'b00011, 1'b1, 8'hA5, 4'h5, 10'd103, 1'b1, 1'b0, 0};
    vecs[7]  = '{2'b10, 5'b00000, 1'b1, 8'hA5, 4'h5, 10'd3,   1'b1, 1'b0, 0};
    vecs[8]  = '{2'b00, 5'b00001, 1'b1, 8'hA5, 4'h5, 10'd3,   1'b1, 1'b0, 0};
    vecs[9]  = '{2'b00, 5'b10010, 1'b1, 8'hA5, 4'h5, 10'd3,   1'b1, 1'(DEPTH == 1), 0};
    vecs[10] = '{2'b01, 5'b11000, 1'b0, 8'h00, 4'h0, 10'd3,   1'b0, 1'b0, 1};
    for (int i = 0; i < 11; i++) begin
      r0 = rcsTotal;
      applyStimulus(vecs[i].op, vecs[i].pay, 4);
      checkOutput($sformatf("vec%0d.valid", i), 32'(txValid), 32'(vecs[i].expValid));
      if (vecs[i].expValid) checkOutput($sformatf("vec%0d.data", i), 32'(txData), 32'(vecs[i].expData));
      checkOutput($sformatf("vec%0d.cfg", i), 32'(cfg), 32'(vecs[i].expCfg));
      checkOutput($sformatf("vec%0d.prediv", i), 32'(prediv), 32'(vecs[i].expPrediv));
      checkOutput($sformatf("vec%0d.errSeq", i), 32'(errSeq), 32'(vecs[i].expSeq));
      checkOutput($sformatf("vec%0d.errOvr", i), 32'(errOvr), 32'(vecs[i].expOvr));
      checkOutput($sformatf("vec%0d.rcsPulses", i), 32'(rcsTotal - r0), 32'(vecs[i].expRcs));
    end

    // Handshake with a ready sink: exactly one valid cycle carrying 0xA5
    doReset();
    txReady = 1'b1;
    applyStimulus(2'b00, 5'b00101, 4);
    v0 = validTotal;
    applyStimulus(2'b00, 5'b11010, 4);
    checkOutput("hs.validCycles", 32'(validTotal - v0), 1);
    checkOutput("hs.data", 32'(lastValidData), 32'hA5);
    checkOutput("hs.validAfter", 32'(txValid), 0);
    txReady = 1'b0;

    // Overrun with a stalled sink, then soft reset
    pushByte(8'h11);
    pushByte(8'h22);
    checkOutput("ovr.data", 32'(txData), 32'h11);
    checkOutput("ovr.flag", 32'(errOvr), 32'(DEPTH == 1));
    r0 = rcsTotal;
    applyStimulus(2'b01, 5'b11000, 4);
    checkOutput("soft.rcsPulses", 32'(rcsTotal - r0), 1);
    checkOutput("soft.valid", 32'(txValid), 0);
    checkOutput("soft.errOvr", 32'(errOvr), 0);

    // Prescaler two-step commit and new tick period
    applyStimulus(2'b10, 5'd3, 4);
    checkOutput("pd.halfWrite", 32'(prediv), 103);
    applyStimulus(2'b10, 5'd0, 4);
    checkOutput("pd.commit", 32'(prediv), 3);
    t0 = tickQ.size();
    repeat (20) @(negedge clk);
    n = tickQ.size() - t0;
    checkOutput("pd.enoughTicks", 32'(n >= 4), 1);
    for (int k = 0; k < 3; k++)
      if (k + 1 < n) checkOutput($sformatf("pd.period%0d", k), 32'(tickQ[t0+k+1] - tickQ[t0+k]), 4);

    // Held strobe: one accept only
    applyStimulus(2'b01, 5'b11000, 4);
    applyStimulus(2'b00, 5'b00101, 4);
    applyStimulus(2'b00, 5'b11111, 20);
    checkOutput("hold1.valid", 32'(txValid), 1);
    checkOutput("hold1.data", 32'(txData), 32'hF5);
    checkOutput("hold1.errSeq", 32'(errSeq), 0);
    applyStimulus(2'b00, 5'b11111, 20);
    checkOutput("hold2.errSeq", 32'(errSeq), 1);
    checkOutput("hold2.data", 32'(txData), 32'hF5);
    checkOutput("hold2.errOvr", 32'(errOvr), 0);

`ifdef UART_CMD_FIFO_EN
    // FIFO fill, overrun on fifth push, in-order drain
    applyStimulus(2'b01, 5'b11000, 4);
    for (int b = 1; b <= 4; b++) begin
      pushByte(8'(b));
      checkOutput($sformatf("fifo.noOvr%0d", b), 32'(errOvr), 0);
    end
    pushByte(8'h05);
    checkOutput("fifo.ovr5", 32'(errOvr), 1);
    txReady = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (txValid) got.push_back(txData);
      @(negedge clk);
    end
    txReady = 1'b0;
    checkOutput("fifo.drainCount", 32'(got.size()), 4);
    for (int k = 0; k < got.size() && k < 4; k++)
      checkOutput($sformatf("fifo.order%0d", k), 32'(got[k]), 32'(k + 1));
`endif

    // Randomized command stream against the reference model
    doReset();
    for (int i = 0; i < 60; i++) begin
      op  = 2'($urandom_range(0, 3));
      pay = 5'($urandom);
      if (op == 2'b01 && $urandom_range(0, 3) == 0) pay = 5'b11000;
      r0 = rcsTotal;
      applyStimulus(op, pay, 4);
      modelCmd(op, pay);
      checkOutput($sformatf("rnd%0d.rcsPulses", i), 32'(rcsTotal - r0), 32'(mExpRcs));
      checkModel($sformatf("rnd%0d", i));
      if (i % 8 == 7) drainAndCheck($sformatf("rnd%0d", i));
    end

    // Reset asserted mid-handshake returns outputs to reset values at once
    applyStimulus(2'b01, 5'b00110, 4);
    pushByte(8'h5A);
    checkOutput("midrst.validBefore", 32'(txValid), 1);
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midrst.valid", 32'(txValid), 0);
    checkOutput("midrst.data", 32'(txData), 0);
    checkOutput("midrst.cfg", 32'(cfg), 0);
    checkOutput("midrst.prediv", 32'(prediv), 103);
    checkOutput("midrst.tick", 32'(baudTick), 0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
